// File: rtl/axi_write_burst.sv
// AXI4 write master: packs an AXI-Stream into fixed-length INCR bursts laid out
// in a ring of AW_STRIDE-spaced blocks, and publishes an acknowledged-block count
// for the downstream read-back stage.
// Optional build macro WR_FLIP_BYTE_EN: byte-reverse the write data lane.
module axi_write_burst #(
    parameter int unsigned                  AW_ADDR_WIDTH = 32,
    parameter int unsigned                  AW_DATA_WIDTH = 64,
    parameter int unsigned                  AW_LEN        = 16,
    parameter int unsigned                  AW_STRIDE     = 4096,
    parameter logic [AW_ADDR_WIDTH-1:0]     WR_START_ADDR = 32'h0000_0000,
    parameter logic [AW_ADDR_WIDTH-1:0]     WR_END_ADDR   = 32'h0010_0000
) (
    input  logic                            m_axi_aclk,
    input  logic                            m_axi_aresetn,
    input  logic [AW_DATA_WIDTH-1:0]        s_wr_tdata,
    input  logic                            s_wr_tvalid,
    output logic                            s_wr_tready,
    input  logic [15:0]                     i_rd_cnt,
    output logic [15:0]                     o_wr_cnt,
    output logic                            o_wr_done,
    output logic                            o_wr_err,
    output logic                            m_axi_awid,
    output logic                            m_axi_awlock,
    output logic [2:0]                      m_axi_awprot,
    output logic [3:0]                      m_axi_awqos,
    output logic [3:0]                      m_axi_awcache,
    output logic [AW_ADDR_WIDTH-1:0]        m_axi_awaddr,
    output logic [7:0]                      m_axi_awlen,
    output logic [2:0]                      m_axi_awsize,
    output logic [1:0]                      m_axi_awburst,
    output logic                            m_axi_awvalid,
    input  logic                            m_axi_awready,
    output logic [AW_DATA_WIDTH-1:0]        m_axi_wdata,
    output logic [AW_DATA_WIDTH/8-1:0]      m_axi_wstrb,
    output logic                            m_axi_wlast,
    output logic                            m_axi_wvalid,
    input  logic                            m_axi_wready,
    input  logic                            m_axi_bid,
    input  logic [1:0]                      m_axi_bresp,
    input  logic                            m_axi_bvalid,
    output logic                            m_axi_bready
);

    localparam int unsigned                 STRB_W   = AW_DATA_WIDTH / 8;
    localparam logic [AW_ADDR_WIDTH-1:0]    STRIDE_A = AW_ADDR_WIDTH'(AW_STRIDE);
    localparam logic [AW_ADDR_WIDTH-1:0]    LAST_BLK = WR_END_ADDR - STRIDE_A;
    localparam int unsigned                 MAX_BLK  = 32'((WR_END_ADDR - WR_START_ADDR) / STRIDE_A);
    localparam logic [7:0]                  AWLEN    = 8'(AW_LEN - 1);
    localparam logic [2:0]                  AWSIZE   = 3'($clog2(STRB_W));

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_WR_RESP,
        ST_DONE
    } state_e;

    state_e                     state_q, state_d;
    logic [AW_ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [AW_ADDR_WIDTH-1:0]   blk_addr_q, blk_addr_d;
    logic [7:0]                 beat_q, beat_d;
    logic [15:0]                wr_cnt_q, wr_cnt_d;
    logic                       wr_err_q, wr_err_d;

    logic [15:0]                used_c;
    logic                       full_c;
    logic                       last_beat_c;
    logic                       unused_bid;

    assign unused_bid  = m_axi_bid;
    assign used_c      = wr_cnt_q - i_rd_cnt;
    assign full_c      = (32'(used_c) >= MAX_BLK);
    assign last_beat_c = (beat_q == AWLEN);

    // Fixed AXI attributes
    assign m_axi_awid    = 1'b0;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awprot  = 3'd0;
    assign m_axi_awqos   = 4'd0;
    assign m_axi_awcache = 4'd3;
    assign m_axi_awlen   = AWLEN;
    assign m_axi_awsize  = AWSIZE;
    assign m_axi_awburst = 2'b01;
    assign m_axi_wstrb   = '1;

    // Handshake outputs decoded from the registered state; data phase is a pass-through
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awvalid = (state_q == ST_WR_ADDR);
    assign m_axi_wvalid  = (state_q == ST_WR_DATA) && s_wr_tvalid;
    assign s_wr_tready   = (state_q == ST_WR_DATA) && m_axi_wready;
    assign m_axi_wlast   = (state_q == ST_WR_DATA) && last_beat_c;
    assign m_axi_bready  = (state_q == ST_WR_RESP);
    assign o_wr_done     = (state_q == ST_DONE);
    assign o_wr_cnt      = wr_cnt_q;
    assign o_wr_err      = wr_err_q;

`ifdef WR_FLIP_BYTE_EN
    // Byte-reversed data lane: byte 0 <-> byte STRB_W-1
    for (genvar g = 0; g < STRB_W; g++) begin : g_flip
        assign m_axi_wdata[8*g +: 8] = s_wr_tdata[8*(STRB_W-1-g) +: 8];
    end
`else
    assign m_axi_wdata = s_wr_tdata;
`endif

    // Next-state and datapath updates for one burst per block
    always_comb begin
        state_d    = state_q;
        awaddr_d   = awaddr_q;
        blk_addr_d = blk_addr_q;
        beat_d     = beat_q;
        wr_cnt_d   = wr_cnt_q;
        wr_err_d   = wr_err_q;
        case (state_q)
            ST_IDLE: begin
                // Ring space is only checked here; a started burst always completes
                if (s_wr_tvalid && !full_c) begin
                    state_d  = ST_WR_ADDR;
                    awaddr_d = blk_addr_q;
                end
            end
            ST_WR_ADDR: begin
                if (m_axi_awready) begin
                    state_d = ST_WR_DATA;
                end
            end
            ST_WR_DATA: begin
                if (s_wr_tvalid && m_axi_wready) begin
                    if (last_beat_c) begin
                        beat_d  = 8'd0;
                        state_d = ST_WR_RESP;
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
            ST_WR_RESP: begin
                if (m_axi_bvalid) begin
                    if (m_axi_bresp != 2'b00) begin
                        wr_err_d = 1'b1;
                    end
                    blk_addr_d = (blk_addr_q >= LAST_BLK) ? WR_START_ADDR : blk_addr_q + STRIDE_A;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                wr_cnt_d = wr_cnt_q + 16'd1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state_q    <= ST_IDLE;
            awaddr_q   <= '0;
            blk_addr_q <= WR_START_ADDR;
            beat_q     <= 8'd0;
            wr_cnt_q   <= 16'd0;
            wr_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            awaddr_q   <= awaddr_d;
            blk_addr_q <= blk_addr_d;
            beat_q     <= beat_d;
            wr_cnt_q   <= wr_cnt_d;
            wr_err_q   <= wr_err_d;
        end
    end

endmodule

// File: tb/tb_axi_write_burst.sv
// Randomized bench for axi_write_burst: stream source, AXI slave responder and a
// transaction-level model of the block ring, data order and counters.
module tb_axi_write_burst;

    localparam int unsigned DW     = 64;
    localparam int unsigned AWID   = 32;
    localparam int unsigned LEN    = 16;
    localparam int unsigned STRIDE = 4096;
    localparam int unsigned START  = 0;
    localparam int unsigned MAXB   = 256;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DW-1:0]     s_wr_tdata;
    logic              s_wr_tvalid;
    logic              s_wr_tready;
    logic [15:0]       i_rd_cnt;
    logic [15:0]       o_wr_cnt;
    logic              o_wr_done;
    logic              o_wr_err;
    logic              awid, awlock;
    logic [2:0]        awprot;
    logic [3:0]        awqos, awcache;
    logic [AWID-1:0]   awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awvalid, awready;
    logic [DW-1:0]     wdata;
    logic [DW/8-1:0]   wstrb;
    logic              wlast, wvalid, wready;
    logic              bid;
    logic [1:0]        bresp;
    logic              bvalid, bready;

    always #5 clk = ~clk;

    axi_write_burst dut (
        .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
        .s_wr_tdata(s_wr_tdata), .s_wr_tvalid(s_wr_tvalid), .s_wr_tready(s_wr_tready),
        .i_rd_cnt(i_rd_cnt), .o_wr_cnt(o_wr_cnt), .o_wr_done(o_wr_done), .o_wr_err(o_wr_err),
        .m_axi_awid(awid), .m_axi_awlock(awlock), .m_axi_awprot(awprot), .m_axi_awqos(awqos),
        .m_axi_awcache(awcache), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen),
        .m_axi_awsize(awsize), .m_axi_awburst(awburst),
        .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready)
    );

    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    // Single comparison point
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Stream word k of the source sequence
    function automatic logic [63:0] word(input int unsigned k);
        return {~k, k};
    endfunction

    // What the write channel must carry for a given stream word
    function automatic logic [63:0] on_bus(input logic [63:0] d);
        logic [63:0] r;
`ifdef WR_FLIP_BYTE_EN
        for (int i = 0; i < 8; i++) r[8*i +: 8] = d[8*(7-i) +: 8];
`else
        r = d;
`endif
        return r;
    endfunction

    // Stimulus knobs (written by the sequencer only)
    int unsigned tv_pct, aw_pct, w_pct, b_pct;
    bit          fixed_mode, rd_track;
    logic [15:0] rd_fixed;
    int          err_burst;

    // Model state (written by the agent process only)
    int unsigned aw_seq, w_bursts, beat_m, b_seq, done_m, pending;
    int unsigned exp_k = 0;
    int unsigned src_k = 0;
    bit          err_m, prev_aw_wait, fire_t, fire_wl, fire_b, fw;

    // Agent: monitor/model on the falling edge, drive inputs just after the rising edge
    initial begin
        s_wr_tvalid = 1'b0; s_wr_tdata = '0; awready = 1'b0; wready = 1'b0;
        bvalid = 1'b0; bresp = 2'b00; bid = 1'b0; i_rd_cnt = 16'd0;
        aw_seq = 0; w_bursts = 0; beat_m = 0; b_seq = 0; done_m = 0; pending = 0;
        err_m = 0; prev_aw_wait = 0; fire_t = 0; fire_wl = 0; fire_b = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                aw_seq = 0; w_bursts = 0; beat_m = 0; b_seq = 0; done_m = 0; pending = 0;
                err_m = 0; prev_aw_wait = 0; fire_t = 0; fire_wl = 0; fire_b = 0;
            end else begin
                if (prev_aw_wait) check("awvalid_hold", 128'(awvalid), 128'(1));
                prev_aw_wait = awvalid && !awready;
                if (awvalid && awready) begin
                    check("awaddr", 128'(awaddr), 128'(START + (aw_seq % MAXB) * STRIDE));
                    aw_seq++;
                end
                fire_t = s_wr_tvalid && s_wr_tready;
                fw     = wvalid && wready;
                if (fire_t || fw) check("stream_vs_w", 128'(fw), 128'(fire_t));
                fire_wl = 0;
                if (fw) begin
                    check("w_after_aw", 128'(aw_seq > w_bursts), 128'(1));
                    check("wdata", 128'(wdata), 128'(on_bus(word(exp_k))));
                    exp_k++;
                    check("wlast", 128'(wlast), 128'(beat_m == LEN - 1));
                    if (beat_m == LEN - 1) begin
                        beat_m = 0; w_bursts++; fire_wl = 1;
                    end else begin
                        beat_m++;
                    end
                end
                fire_b = bvalid && bready;
                if (fire_b) begin
                    b_seq++;
                    if (bresp != 2'b00) err_m = 1;
                end
                if (o_wr_done) begin
                    check("cnt_at_done", 128'(o_wr_cnt), 128'(16'(done_m)));
                    check("done_per_b", 128'(b_seq), 128'(done_m + 1));
                    check("err_at_done", 128'(o_wr_err), 128'(err_m));
                    done_m++;
                end
            end
            @(posedge clk);
            #1;
            if (fire_t) src_k++;
            s_wr_tvalid = ($urandom_range(99) < tv_pct);
            s_wr_tdata  = fixed_mode ? 64'h0102030405060708 : word(src_k);
            awready     = ($urandom_range(99) < aw_pct);
            wready      = ($urandom_range(99) < w_pct);
            if (fire_b && pending > 0) pending--;
            if (fire_wl) pending++;
            if (!rst_n || pending == 0) bvalid = 1'b0;
            else if (fire_b || !bvalid) bvalid = ($urandom_range(99) < b_pct);
            bresp    = (int'(b_seq) == err_burst) ? 2'b10 : 2'b00;
            i_rd_cnt = rd_track ? 16'(done_m) : rd_fixed;
        end
    end

    // Wait until the model has seen target done pulses, bounded
    task automatic wait_done(input int unsigned target, input int unsigned budget);
        int unsigned n = 0;
        while (done_m < target && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        check("wait_done", 128'(done_m >= target), 128'(1));
    endtask

    // Sequencer
    initial begin
        int unsigned n;
        rst_n = 1'b0;
        tv_pct = 0; aw_pct = 100; w_pct = 100; b_pct = 100;
        fixed_mode = 1; rd_track = 0; rd_fixed = 16'd0; err_burst = -1;
        repeat (3) @(negedge clk);
        #1;
        // Reset values and constant attributes
        check("rst_awvalid", 128'(awvalid), 128'(0));
        check("rst_wvalid", 128'(wvalid), 128'(0));
        check("rst_bready", 128'(bready), 128'(0));
        check("rst_tready", 128'(s_wr_tready), 128'(0));
        check("rst_cnt", 128'(o_wr_cnt), 128'(0));
        check("rst_done", 128'(o_wr_done), 128'(0));
        check("rst_err", 128'(o_wr_err), 128'(0));
        check("rst_awaddr", 128'(awaddr), 128'(0));
        check("awlen", 128'(awlen), 128'(LEN - 1));
        check("awsize", 128'(awsize), 128'(3));
        check("awburst", 128'(awburst), 128'(1));
        check("awcache", 128'(awcache), 128'(3));
        check("wstrb", 128'(wstrb), 128'(8'hFF));
        check("aw_zero_attrs", 128'({awid, awlock, awprot, awqos}), 128'(0));
`ifdef WR_FLIP_BYTE_EN
        check("wdata_lane", 128'(wdata), 128'(64'h0807060504030201));
`else
        check("wdata_lane", 128'(wdata), 128'(64'h0102030405060708));
`endif

        // Full rate, reader keeping up: runs past the ring wrap
        fixed_mode = 0; tv_pct = 100; rd_track = 1;
        @(negedge clk);
        rst_n = 1'b1;
        wait_done(258, 258 * 40);

        // Reset in the middle of a data phase
        n = 0;
        while (!(wvalid && beat_m >= 4) && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        check("found_mid_burst", 128'(wvalid), 128'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_awvalid", 128'(awvalid), 128'(0));
        check("mid_rst_wvalid", 128'(wvalid), 128'(0));
        check("mid_rst_tready", 128'(s_wr_tready), 128'(0));
        check("mid_rst_cnt", 128'(o_wr_cnt), 128'(0));
        check("mid_rst_awaddr", 128'(awaddr), 128'(0));

        // Random stalls, error response on the third burst
        rd_track = 0; rd_fixed = 16'd0;
        tv_pct = 70; aw_pct = 50; w_pct = 60; b_pct = 50; err_burst = 2;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_done(20, 20000);
        @(negedge clk); #1;
        check("cnt_after_stall", 128'(o_wr_cnt), 128'(16'(done_m)));
        check("err_sticky", 128'(o_wr_err), 128'(1));

        // Reader stalled at 0: ring fills and the writer parks
        err_burst = -1; tv_pct = 100; aw_pct = 100; w_pct = 100; b_pct = 100;
        wait_done(256, 20000);
        repeat (100) @(negedge clk);
        #1;
        check("full_aw_count", 128'(aw_seq), 128'(256));
        check("full_done_count", 128'(done_m), 128'(256));
        check("full_cnt", 128'(o_wr_cnt), 128'(256));
        check("full_tready", 128'(s_wr_tready), 128'(0));
        check("full_awvalid", 128'(awvalid), 128'(0));
        check("full_err_kept", 128'(o_wr_err), 128'(1));

        // One block freed: exactly one more burst, back at the ring start
        rd_fixed = 16'd1;
        wait_done(257, 2000);
        repeat (60) @(negedge clk);
        #1;
        check("freed_aw_count", 128'(aw_seq), 128'(257));
        check("freed_cnt", 128'(o_wr_cnt), 128'(257));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
